// File: rtl/lcu_streamer.sv
// Streams a 128x128 frame as 8x8 LCUs of 16x16 pixels to an IPF, with a 2-entry
// skid buffer for read latency under back-pressure and prefetched LCU parameters.
module lcu_streamer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        busy,
  output logic        img_rd,
  output logic [13:0] img_addr,
  input  logic [7:0]  img_data,
  output logic        par_rd,
  output logic [5:0]  par_addr,
  input  logic [23:0] par_data,
  output logic        in_en,
  output logic [7:0]  din,
  output logic [1:0]  ipf_type,
  output logic [4:0]  ipf_band_pos,
  output logic        ipf_wo_class,
  output logic [15:0] ipf_offset,
  output logic [2:0]  lcu_x,
  output logic [2:0]  lcu_y,
  output logic [1:0]  lcu_size,
  output logic        done,
  output logic        active
);

  // Handshake: a pixel moves to the IPF on every rising edge where in_en=1;
  // busy sampled high at an edge forces in_en low for the following cycle.
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  state_t      state_q, state_d;
  logic [14:0] rd_cnt_q;
  logic        rd_pend_q;
  logic [14:0] ld_cnt_q;
  logic [7:0]  fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  fifo_cnt_q;
  logic        in_en_q;
  logic [7:0]  din_q;
  logic        par_rd_q;
  logic [5:0]  par_addr_q;
  logic        par_pend_q;
  logic [23:0] shadow_q;
  logic [23:0] par_cur_q;
  logic [2:0]  lcu_x_q, lcu_y_q;

  logic        start_acc, issue, avail, load, bypass, push, pop, last_xfer, lcu_start;
  logic [7:0]  load_pix;
  logic [23:0] par_src;

  always_comb begin
    start_acc = (state_q == IDLE) && start;
    // Reserve a buffer slot for every read in flight, ignoring pending pops.
    issue     = ((state_q == PRIME) || (state_q == STREAM)) && !rd_cnt_q[14] &&
                (({1'b0, rd_pend_q} + fifo_cnt_q) < 2'd2);
    avail     = (fifo_cnt_q != 2'd0) || rd_pend_q;
    load      = (state_q == STREAM) && !busy && avail;
    bypass    = load && (fifo_cnt_q == 2'd0);
    push      = rd_pend_q && !bypass;
    pop       = load && (fifo_cnt_q != 2'd0);
    load_pix  = (fifo_cnt_q == 2'd0) ? img_data : fifo_q[rd_ptr_q];
    last_xfer = in_en_q && (ld_cnt_q == 15'd16384);
    lcu_start = load && (ld_cnt_q[7:0] == 8'd0);
    // The very first LCU's parameters arrive on the edge its pixel 0 is presented.
    par_src   = par_pend_q ? par_data : shadow_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PRIME;
      PRIME:   state_d = STREAM;
      STREAM:  if (last_xfer) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      rd_pend_q  <= 1'b0;
      ld_cnt_q   <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
      in_en_q    <= 1'b0;
      din_q      <= '0;
      par_rd_q   <= 1'b0;
      par_addr_q <= '0;
      par_pend_q <= 1'b0;
      shadow_q   <= '0;
      par_cur_q  <= '0;
      lcu_x_q    <= '0;
      lcu_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= issue;
      in_en_q    <= load;
      par_pend_q <= par_rd_q;
      if (par_pend_q) shadow_q <= par_data;
      if (start_acc) begin
        rd_cnt_q   <= '0;
        ld_cnt_q   <= '0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        fifo_cnt_q <= '0;
        par_rd_q   <= 1'b1;
        par_addr_q <= '0;
      end else begin
        if (issue) rd_cnt_q <= rd_cnt_q + 15'd1;
        if (push) begin
          fifo_q[wr_ptr_q] <= img_data;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        if (load) begin
          din_q    <= load_pix;
          ld_cnt_q <= ld_cnt_q + 15'd1;
        end
        // Prefetch LCU k+1 parameters as LCU k begins.
        par_rd_q <= lcu_start && (ld_cnt_q[13:8] != 6'd63);
        if (lcu_start) begin
          par_addr_q <= ld_cnt_q[13:8] + 6'd1;
          par_cur_q  <= par_src;
          lcu_x_q    <= ld_cnt_q[10:8];
          lcu_y_q    <= ld_cnt_q[13:11];
        end
      end
    end
  end

  assign img_rd       = issue;
  assign img_addr     = {rd_cnt_q[13:11], rd_cnt_q[7:4], rd_cnt_q[10:8], rd_cnt_q[3:0]};
  assign par_rd       = par_rd_q;
  assign par_addr     = par_addr_q;
  assign in_en        = in_en_q;
  assign din          = din_q;
  assign ipf_type     = par_cur_q[23:22];
  assign ipf_band_pos = par_cur_q[21:17];
  assign ipf_wo_class = par_cur_q[16];
  assign ipf_offset   = par_cur_q[15:0];
  assign lcu_x        = lcu_x_q;
  assign lcu_y        = lcu_y_q;
  assign lcu_size     = 2'd0;
  assign done         = (state_q == DONE);
  assign active       = (state_q != IDLE);

endmodule

// File: tb/tb_lcu_streamer.sv
// Directed bench for lcu_streamer: full frames with and without back-pressure,
// an ignored second start, and a mid-frame reset followed by a clean restart.
module tb_lcu_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy = 1'b0;
  logic        img_rd;
  logic [13:0] img_addr;
  logic [7:0]  img_data;
  logic        par_rd;
  logic [5:0]  par_addr;
  logic [23:0] par_data;
  logic        in_en;
  logic [7:0]  din;
  logic [1:0]  ipf_type;
  logic [4:0]  ipf_band_pos;
  logic        ipf_wo_class;
  logic [15:0] ipf_offset;
  logic [2:0]  lcu_x, lcu_y;
  logic [1:0]  lcu_size;
  logic        done, active;

  lcu_streamer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
    .par_rd(par_rd), .par_addr(par_addr), .par_data(par_data),
    .in_en(in_en), .din(din),
    .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
    .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
    .done(done), .active(active)
  );

  // clock / reset / memories
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pixel[a] = a[7:0], param[i] = i; garbage when no read was issued
  always @(posedge clk) begin
    img_data <= img_rd ? img_addr[7:0] : 8'($urandom);
    par_data <= par_rd ? {18'd0, par_addr} : 24'($urandom);
  end

  // scoreboard state
  logic [29:0] rcv_q[$];
  logic [29:0] exp_q[$];
  logic [13:0] rd_q[$];
  logic [13:0] exp_addr_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  bit busy_mode = 1'b0;
  bit burst_done = 1'b0;
  int burst_left = 0;
  int done_n, overlap_n, active_n, size_bad, stall_bad, type_bad;
  int first_cyc, last_cyc, done_cyc;

  always @(negedge clk) begin
    if (mon_on) begin
      if (in_en) begin
        rcv_q.push_back({ipf_offset, lcu_y, lcu_x, din});
        if (rcv_q.size() == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (img_rd) rd_q.push_back(img_addr);
      if (done) begin done_n++; done_cyc = cyc; end
      if (done && in_en) overlap_n++;
      if (active) active_n++;
      if (lcu_size !== 2'd0) size_bad++;
      if (busy && in_en) stall_bad++;
      if (in_en && ({ipf_type, ipf_band_pos, ipf_wo_class} !== 8'd0)) type_bad++;
    end
    if (!busy_mode) busy = 1'b0;
    else if (burst_left > 0) begin busy = 1'b1; burst_left--; end
    else if (!burst_done && rcv_q.size() == 255) begin busy = 1'b1; burst_left = 19; burst_done = 1'b1; end
    else busy = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clear_mon();
    rcv_q.delete(); rd_q.delete();
    done_n = 0; overlap_n = 0; active_n = 0; size_bad = 0; stall_bad = 0; type_bad = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start(output int s_cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; s_cyc = cyc;
  endtask

  task automatic run_frame(input int repulse_at, input int budget, output int s_cyc);
    bit pulsed = 1'b0;
    int k = 0;
    clear_mon();
    mon_on = 1'b1;
    pulse_start(s_cyc);
    while (done_n == 0 && k < budget) begin
      @(negedge clk);
      k++;
      if (repulse_at >= 0 && !pulsed && rcv_q.size() >= repulse_at) begin
        start = 1'b1; pulsed = 1'b1;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk("frame_done_seen", 64'(done_n > 0), 64'd1);
    repeat (4) @(negedge clk);
    mon_on = 1'b0;
  endtask

  task automatic check_frame(input string tag, input bit timing, input int s_cyc);
    int data_bad = 0, lcu_bad = 0, addr_bad = 0;
    int n_cmp;
    logic [29:0] e256, e2048;
    exp_q.delete(); exp_addr_q.delete();
    for (int n = 0; n < 16384; n++) begin
      int ly = n / 2048, lx = (n / 256) % 8, row = (n / 16) % 16, col = n % 16;
      logic [13:0] a = 14'(ly * 2048 + row * 128 + lx * 16 + col);
      exp_q.push_back({16'(n / 256), 3'(ly), 3'(lx), a[7:0]});
      exp_addr_q.push_back(a);
    end
    chk({tag, "_xfer_count"}, 64'(rcv_q.size()), 64'd16384);
    chk({tag, "_read_count"}, 64'(rd_q.size()), 64'd16384);
    n_cmp = (rcv_q.size() < 16384) ? rcv_q.size() : 16384;
    for (int i = 0; i < n_cmp; i++) begin
      if (rcv_q[i][7:0] !== exp_q[i][7:0]) data_bad++;
      if (rcv_q[i][29:8] !== exp_q[i][29:8]) lcu_bad++;
    end
    n_cmp = (rd_q.size() < 16384) ? rd_q.size() : 16384;
    for (int i = 0; i < n_cmp; i++)
      if (rd_q[i] !== exp_addr_q[i]) addr_bad++;
    chk({tag, "_pixel_mismatches"}, 64'(data_bad), 64'd0);
    chk({tag, "_param_lcu_mismatches"}, 64'(lcu_bad), 64'd0);
    chk({tag, "_read_addr_mismatches"}, 64'(addr_bad), 64'd0);
    e256  = (rcv_q.size() > 256)  ? rcv_q[256]  : 'x;
    e2048 = (rcv_q.size() > 2048) ? rcv_q[2048] : 'x;
    chk({tag, "_lcu_xy_at_256"}, 64'(e256[13:8]), 64'(6'b000_001));
    chk({tag, "_lcu_xy_at_2048"}, 64'(e2048[13:8]), 64'(6'b001_000));
    chk({tag, "_done_count"}, 64'(done_n), 64'd1);
    chk({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_cyc + 1));
    chk({tag, "_done_in_en_overlap"}, 64'(overlap_n), 64'd0);
    chk({tag, "_lcu_size_nonzero"}, 64'(size_bad), 64'd0);
    chk({tag, "_in_en_after_busy"}, 64'(stall_bad), 64'd0);
    chk({tag, "_ipf_type_band_wo"}, 64'(type_bad), 64'd0);
    if (timing) begin
      chk({tag, "_first_in_en_edge"}, 64'(first_cyc), 64'(s_cyc + 2));
      chk({tag, "_active_cycles"}, 64'(active_n), 64'd16387);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({in_en, din, img_rd, img_addr, par_rd, par_addr, ipf_type, ipf_band_pos,
                ipf_wo_class, ipf_offset, lcu_x, lcu_y, done, active});
  endfunction

  // directed sequence
  initial begin
    int s_cyc;
    int k;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", all_outs(), 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_active_low", 64'(active), 64'd0);

    // frame 1: busy=0, start re-pulsed at transfer 1000
    run_frame(1000, 20000, s_cyc);
    check_frame("f1", 1'b1, s_cyc);

    // frame 2: random busy plus a 20-cycle burst at transfer 255
    busy_mode = 1'b1;
    run_frame(-1, 45000, s_cyc);
    busy_mode = 1'b0;
    check_frame("f2", 1'b0, s_cyc);
    chk("f2_burst_happened", 64'(burst_done), 64'd1);

    // frame 3: reset at transfer 5000
    clear_mon();
    mon_on = 1'b1;
    pulse_start(s_cyc);
    k = 0;
    while (rcv_q.size() < 5000 && k < 8000) begin @(negedge clk); k++; end
    chk("f3_reached_5000", 64'(rcv_q.size() >= 5000), 64'd1);
    mon_on = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("f3_reset_outputs_1", all_outs(), 64'd0);
    @(negedge clk);
    chk("f3_reset_outputs_2", all_outs(), 64'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("f3_idle_after_reset", 64'({active, in_en, img_rd}), 64'd0);

    // frame 4: clean restart after abort
    run_frame(-1, 20000, s_cyc);
    chk("f4_first_pixel", 64'((rcv_q.size() > 0) ? rcv_q[0] : 'x), 64'd0);
    chk("f4_first_read_addr", 64'((rd_q.size() > 0) ? rd_q[0] : 'x), 64'd0);
    check_frame("f4", 1'b1, s_cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcu_streamer.md
LCU_STREAMER -- requirements
Module: lcu_streamer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, and its ports SHALL be exactly those listed in REQ-002 to REQ-019.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; while low, every register holds its reset value.
REQ-004 start  in  1  one-cycle pulse requesting a frame transfer; honoured only in IDLE.
REQ-005 busy  in  1  IPF back-pressure; high = IPF not accepting pixels.
REQ-006 img_rd  out  1  pixel-memory read strobe.
REQ-007 img_addr  out  14  pixel-memory address = lcu_y*2048 + row*128 + lcu_x*16 + col.
REQ-008 img_data  in  8  pixel read data, valid exactly one cycle after img_rd.
REQ-009 par_rd  out  1  parameter-memory read strobe.
REQ-010 par_addr  out  6  parameter-memory address = {lcu_y, lcu_x}.
REQ-011 par_data  in  24  {type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}, valid one cycle after par_rd.
REQ-012 in_en  out  1  din valid; one pixel transfers on each rising edge where in_en=1.
REQ-013 din  out  8  pixel data.
REQ-014 ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset  out  2/5/1/16  current-LCU parameters.
REQ-015 lcu_x  out  3  current-LCU column.
REQ-016 lcu_y  out  3  current-LCU row.
REQ-017 lcu_size  out  2  constant 2'd0, meaning 16x16.
REQ-018 done  out  1  one-cycle pulse after the last pixel transfers.
REQ-019 active  out  1  high from start acceptance until done.

Function
REQ-020 The frame SHALL be 128x128 pixels, split into 8x8 LCUs of 16x16 pixels each.
REQ-021 LCUs SHALL be sent in raster order: lcu_x 0..7 within each lcu_y 0..7.
REQ-022 Pixels within an LCU SHALL be sent row-major: col 0..15 within each row 0..15.
REQ-023 The module SHALL use the states IDLE, PRIME, STREAM and DONE.
REQ-024 IDLE -> PRIME on start=1; start in any other state SHALL be ignored.
REQ-025 PRIME SHALL read par_addr 0 and img_addr 0, then go to STREAM.
REQ-026 STREAM -> DONE on the edge that transfers pixel 16383.
REQ-027 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-028 With busy=0, the first in_en=1 SHALL occur on the 3rd rising edge after the edge that sampled start=1.
REQ-029 With busy=0, in_en SHALL then stay high for exactly 16384 consecutive cycles, with no bubbles at LCU boundaries.
REQ-030 in_en SHALL be registered: if busy=1 is sampled at an edge, in_en SHALL be 0 in the following cycle.
REQ-031 A pixel presented while stalled SHALL be re-presented unchanged once busy falls; no pixel is dropped or duplicated.
REQ-032 A 2-entry pixel buffer SHALL absorb the read already in flight when a stall begins.
REQ-033 img_rd SHALL be issued only when a buffer slot is free at data return, so the buffer never overflows.
REQ-034 Parameters for LCU k+1 SHALL be prefetched during LCU k and held in a shadow register.
REQ-035 The shadow parameters SHALL move to the ipf_* and lcu_x/lcu_y outputs on the same edge that presents pixel 0 of LCU k+1.
REQ-036 Parameter and lcu_x/lcu_y outputs SHALL stay constant for all 256 pixels of an LCU, including across stalls.
REQ-037 Address counters SHALL wrap: col 15->0 increments row; row 15->0 increments lcu_x; lcu_x 7->0 increments lcu_y.
REQ-038 No read SHALL be issued beyond address 16383 or parameter index 63.
REQ-039 done and in_en SHALL never be high in the same cycle.
REQ-040 active SHALL be low in IDLE.

Reset
REQ-041 While reset=0, these outputs SHALL be 0: in_en, din, img_rd, img_addr, par_rd, par_addr, all ipf_* outputs, lcu_x, lcu_y, done, active.
REQ-042 While reset=0, the FSM SHALL be in IDLE and the pixel buffer SHALL be empty.
REQ-043 Reset asserted mid-frame SHALL abort the transfer immediately; after release the module waits in IDLE for a new start.

Verification
REQ-044 Directed tests SHALL cover all of the following:
- Memory with pixel[a] = a[7:0], busy=0: 16384 transfers; transfer n carries pixel of address lcu_y*2048+row*128+lcu_x*16+col; done 1 cycle after the last transfer.
- Parameter memory with entry i = i: ipf_offset changes exactly at each 256-transfer boundary; lcu_x/lcu_y = (1,0) at transfer 256 and (0,1) at transfer 2048.
- Random busy (50%) plus a 20-cycle busy burst at transfer 255: received sequence identical to the busy=0 case, no drops or duplicates.
- start pulsed again at transfer 1000: ignored, exactly one done.
- reset=0 at transfer 5000: all outputs 0 within the reset; after a new start, transfer 0 = address 0.
- lcu_size = 0 throughout; active high from PRIME until done.
